// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg
//   Shared types and helpers for the counter scheduler and its arbiter.
//   - state_e   : scheduler FSM state (IDLE -> LOAD -> RUN -> DONE -> IDLE)
//   - id_width  : bit width needed to index a set of n requesters
package counter_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Never returns 0 so a requester index always has at least one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. The search starts one position after
//   last_grant and wraps, so the most recently served requester has the
//   lowest priority.
//   Ports:
//     req        in  N    request vector
//     last_grant in  IDW  index of the previously granted requester
//     grant      out N    one-hot grant (all zero when nothing requested)
//     grant_idx  out IDW  index of the granted requester
//     any_grant  out 1    at least one request present
module rr_arbiter
  import counter_sched_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_grant,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           any_grant
);

  // Requests rotated so that position 0 is the highest-priority slot.
  logic [IDW-1:0] rot_idx [N];
  logic [N-1:0]   rot_req;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      // last_grant + 1 + gi lies below 2N, so one conditional subtract wraps it.
      logic [IDW:0] sum;
      assign sum          = {1'b0, last_grant} + (IDW+1)'(gi + 1);
      assign rot_idx[gi]  = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N))
                                                 : sum[IDW-1:0];
      assign rot_req[gi]  = req[rot_idx[gi]];
    end
  endgenerate

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = |rot_req;
    // Scan from lowest priority to highest so the highest set slot wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        grant_idx = rot_idx[k];
      end
    end
    if (any_grant) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/counter_sched.sv
// counter_sched
//   Round-robin scheduler time-sharing one WIDTH-bit up-counter among
//   NUM_REQ requesters. A granted job of N ticks loads the counter with
//   2^WIDTH - N, enables it until overflow, then pulses done to the owner.
//   Ports:
//     clk           in  1              clock
//     rst           in  1              synchronous active-high reset
//     req_valid     in  NUM_REQ        per-requester request
//     req_interval  in  NUM_REQ*WIDTH  flattened intervals, slice i = req i
//     req_ready     out NUM_REQ        one-hot acceptance (IDLE only)
//     done          out NUM_REQ        one-cycle completion pulse
//     busy          out 1              FSM not in IDLE
//     active_id     out IDW            granted requester, valid while busy
//     cnt_load      out 1              counter load strobe
//     cnt_load_data out WIDTH          counter load value
//     cnt_enable    out 1              counter enable
//     cnt_overflow  in  1              counter overflow flag
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int IDW     = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_interval,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [IDW-1:0]           active_id,
  output logic                     cnt_load,
  output logic [WIDTH-1:0]         cnt_load_data,
  output logic                     cnt_enable,
  input  logic                     cnt_overflow
);

  state_e         state_reg, state_next;
  logic [IDW-1:0] last_grant_reg;
  logic [IDW-1:0] active_id_reg;
  logic [WIDTH-1:0] interval_reg;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDW-1:0]     arb_idx;
  logic               arb_any;
  logic               handshake;

  logic [WIDTH-1:0] interval_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign interval_arr[gi] = req_interval[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any_grant  (arb_any)
  );

  // A grant is never advertised while reset is asserted, since reset wins
  // over the IDLE -> LOAD transition.
  assign handshake = (state_reg == IDLE) && arb_any && !rst;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Grant bookkeeping; the pointer moves only on a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= IDW'(NUM_REQ - 1);
      active_id_reg  <= '0;
      interval_reg   <= '0;
    end else if (handshake) begin
      last_grant_reg <= arb_idx;
      active_id_reg  <= arb_idx;
      interval_reg   <= interval_arr[arb_idx];
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (handshake) state_next = LOAD;
      LOAD:    state_next = RUN;
      RUN:     if (cnt_overflow) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready     = '0;
    done          = '0;
    cnt_load      = 1'b0;
    cnt_load_data = '0;
    cnt_enable    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (handshake) req_ready = arb_grant;
      end
      LOAD: begin
        // Two's complement of N: the counter wraps after exactly N ticks,
        // and N = 0 loads 0 for a full 2^WIDTH-tick period.
        cnt_load      = 1'b1;
        cnt_load_data = WIDTH'(0) - interval_reg;
      end
      RUN: begin
        // Dropping enable on overflow parks the counter at 0.
        cnt_enable = !cnt_overflow;
      end
      DONE: begin
        if (!rst) done[active_id_reg] = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (state_reg != IDLE);
  assign active_id = active_id_reg;

endmodule

// File: tb/tb_counter_sched.sv
module tb_counter_sched;

  localparam int NR = 4;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*W-1:0] req_interval = '0;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   done;
  logic            busy;
  logic [1:0]      active_id;
  logic            cnt_load;
  logic [W-1:0]    cnt_load_data;
  logic            cnt_enable;
  logic            cnt_overflow;

  counter_sched #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_interval  (req_interval),
    .req_ready     (req_ready),
    .done          (done),
    .busy          (busy),
    .active_id     (active_id),
    .cnt_load      (cnt_load),
    .cnt_load_data (cnt_load_data),
    .cnt_enable    (cnt_enable),
    .cnt_overflow  (cnt_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Attached counter: load clears overflow, enable increments, wrap sets
  // a sticky overflow flag. It has no reset of its own.
  logic [W-1:0] cnt_q = '0;
  logic         ovf_q = 1'b0;
  always @(posedge clk) begin
    if (cnt_load) begin
      cnt_q <= cnt_load_data;
      ovf_q <= 1'b0;
    end else if (cnt_enable) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == '1) ovf_q <= 1'b1;
    end
  end
  assign cnt_overflow = ovf_q;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference rules: grant the first valid requester after the last grant.
  function automatic int model_pick(input logic [NR-1:0] mask, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (mask[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  function automatic int model_load(input int n);
    return (256 - n) % 256;
  endfunction

  function automatic int model_ticks(input int n);
    return (n == 0) ? 256 : n;
  endfunction

  // Called at the negedge of the handshake cycle t0. Returns at the negedge
  // of cycle t0+ticks+4 (the next IDLE cycle).
  task automatic observe_job(input int id, input int load, input int ticks,
                             input logic [NR-1:0] drop);
    int t0, en_cnt, en_first, done_cyc, done_val;
    t0 = cyc;
    en_cnt = 0; en_first = -1; done_cyc = -1; done_val = 0;
    @(posedge clk); #1;
    req_valid = req_valid & ~drop;
    @(negedge clk);
    chk("load_strobe", int'(cnt_load), 1);
    chk("load_data", int'(cnt_load_data), load);
    chk("active_id", int'(active_id), id);
    chk("busy_load", int'(busy), 1);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (cnt_enable) begin
        en_cnt++;
        if (en_first < 0) en_first = cyc;
      end
      if (done != '0) begin
        done_cyc = cyc;
        done_val = int'(done);
        break;
      end
    end
    if (done_cyc < 0) chk("done_timeout", 0, 1);
    chk("enable_count", en_cnt, ticks);
    chk("enable_first", en_first - t0, 2);
    chk("done_time", done_cyc - t0, ticks + 3);
    chk("done_vec", done_val, 1 << id);
    @(negedge clk);
    chk("busy_after", int'(busy), 0);
    $display("job id=%0d ticks=%0d t0=%0d done_at=+%0d", id, ticks, t0, done_cyc - t0);
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    logic [31:0]   ivs;       // {iv3, iv2, iv1, iv0}
    int            exp_id;
    int            exp_load;
    int            exp_ticks;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int ts, last, exp_id, n;
    logic [NR-1:0] mask;

    vecs[0] = '{4'b0001, 32'h00_00_00_05, 0, 251, 5};
    vecs[1] = '{4'b0010, 32'h00_00_00_00, 1,   0, 256};
    vecs[2] = '{4'b0100, 32'h00_01_00_00, 2, 255, 1};
    vecs[3] = '{4'b1000, 32'hFF_00_00_00, 3,   1, 255};
    vecs[4] = '{4'b1010, 32'h09_00_07_00, 1, 249, 7};
    vecs[5] = '{4'b1001, 32'h04_00_00_02, 3, 252, 4};

    // Reset state, with requests pending to show reset blocks the handshake.
    rst = 1'b1;
    req_valid = '1;
    req_interval = 32'h03_03_03_03;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_load", int'(cnt_load), 0);
    chk("rst_load_data", int'(cnt_load_data), 0);
    chk("rst_enable", int'(cnt_enable), 0);
    chk("rst_active_id", int'(active_id), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;

    // Table-driven single jobs.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      req_valid = vecs[i].valid;
      req_interval = vecs[i].ivs;
      @(negedge clk);
      chk("tbl_ready", int'(req_ready), 1 << vecs[i].exp_id);
      observe_job(vecs[i].exp_id, vecs[i].exp_load, vecs[i].exp_ticks, '1);
      if (vecs[i].exp_ticks == 256) chk("parked_cnt", int'(cnt_q), 0);
    end

    // Simultaneous requests, pointer at 3: grants 0,1,2 spaced 7 cycles.
    @(posedge clk); #1;
    req_valid = 4'b0111;
    req_interval = 32'h00_03_03_03;
    @(negedge clk);
    ts = cyc;
    chk("sim_ready0", int'(req_ready), 1);
    observe_job(0, 253, 3, 4'b0001);
    chk("sim_grant1_time", cyc - ts, 7);
    chk("sim_ready1", int'(req_ready), 2);
    observe_job(1, 253, 3, 4'b0010);
    chk("sim_grant2_time", cyc - ts, 14);
    chk("sim_ready2", int'(req_ready), 4);
    observe_job(2, 253, 3, 4'b0100);

    // Fairness: req0 and req1 held continuously, pointer at 2.
    @(posedge clk); #1;
    req_valid = 4'b0011;
    req_interval = 32'h00_00_02_02;
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      chk("fair_ready", int'(req_ready), 1 << (j % 2));
      observe_job(j % 2, 254, 2, (j == 3) ? 4'b0011 : 4'b0000);
    end

    // Reset during RUN of a 20-tick job, pointer at 1 so req0 is granted.
    @(posedge clk); #1;
    req_valid = 4'b0001;
    req_interval = 32'h00_00_00_14;
    @(negedge clk);
    chk("rr_ready", int'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(negedge clk);
    chk("rr_running", int'(cnt_enable), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rr_busy", int'(busy), 0);
    chk("rr_enable", int'(cnt_enable), 0);
    chk("rr_done0", int'(done), 0);
    @(negedge clk);
    chk("rr_done1", int'(done), 0);
    rst = 1'b0;
    req_valid = 4'b0011;
    req_interval = 32'h00_00_04_04;
    #1;
    chk("rr_ptr_reset", int'(req_ready), 1);
    observe_job(0, 252, 4, 4'b0011);
    chk("rr_no_done_extra", int'(done), 0);

    // Randomised jobs against the round-robin rules.
    last = 0;
    for (int r = 0; r < 40; r++) begin
      @(posedge clk); #1;
      mask = NR'($urandom_range(1, 15));
      for (int i = 0; i < NR; i++) begin
        req_interval[i*W +: W] = ($urandom_range(0, 24) == 0) ? 8'd0
                                 : W'($urandom_range(1, 12));
      end
      req_valid = mask;
      @(negedge clk);
      exp_id = model_pick(mask, last);
      n = int'(req_interval[exp_id*W +: W]);
      chk("rnd_ready", int'(req_ready), 1 << exp_id);
      observe_job(exp_id, model_load(n), model_ticks(n), '1);
      last = exp_id;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
